capture_ring_writer: RTL and testbench

- Streaming sample-capture engine that writes 32-bit instrument samples into the dual-port on-chip sample memory through its second Avalon slave port (s2: address2/writedata2/byteenable2/chipselect2/write2).
- Runs a circular buffer with pre-trigger fill, trigger arm and post-trigger count.
- Reports the trigger address and completion so the CPU can read the capture back through port s1.
- The memory accepts one write per cycle with no waitrequest, so this block never stalls on the memory side.

---
 rtl/capture_ring_writer.sv | 125 ++++++++++++
 tb/tb_capture_ring_writer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/capture_ring_writer.sv
// Circular sample-capture engine: streams 32-bit samples into the s2 port of the
// sample memory with pre-trigger fill, trigger detection and post-trigger count.
module capture_ring_writer #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              trigger,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic              wrapped,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_writedata;
    logic              r_mem_write;
    logic              r_triggered;
    logic              r_wrapped;
    logic [ADDR_W-1:0] r_trig_addr;

    logic w_busy;
    logic w_accept;
    logic w_arm_ok;

    assign w_busy   = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_accept = sample_valid & w_busy;
    assign w_arm_ok = arm & ~abort & ((r_state == S_IDLE) || (r_state == S_DONE));

    assign sample_ready   = w_busy;
    assign busy           = w_busy;
    assign done           = (r_state == S_DONE);
    assign mem_address    = r_mem_address;
    assign mem_writedata  = r_mem_writedata;
    assign mem_byteenable = 4'b1111;
    assign mem_chipselect = r_mem_write;
    assign mem_write      = r_mem_write;
    assign triggered      = r_triggered;
    assign wrapped        = r_wrapped;
    assign trig_addr      = r_trig_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_pre_cnt       <= '0;
            r_post_cnt      <= '0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_mem_write     <= 1'b0;
            r_triggered     <= 1'b0;
            r_wrapped       <= 1'b0;
            r_trig_addr     <= '0;
        end else begin
            // A beat accepted in the abort cycle is still written; only control is dropped.
            r_mem_write <= w_accept;
            if (w_accept) begin
                r_mem_address   <= r_ptr;
                r_mem_writedata <= sample_data;
                r_ptr           <= r_ptr + ADDR_W'(1);
            end

            if (abort) begin
                r_state <= S_IDLE;
            end else if (w_arm_ok) begin
                r_ptr       <= start_addr;
                r_pre_cnt   <= pre_count;
                r_post_cnt  <= post_count;
                r_triggered <= 1'b0;
                r_wrapped   <= 1'b0;
                r_trig_addr <= '0;
                r_state     <= (pre_count == '0) ? S_ARMED : S_PRE;
            end else if (w_accept) begin
                if (r_ptr == '1)
                    r_wrapped <= 1'b1;
                case (r_state)
                    S_PRE: begin
                        r_pre_cnt <= r_pre_cnt - ADDR_W'(1);
                        if (r_pre_cnt == ADDR_W'(1))
                            r_state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (trigger) begin
                            r_trig_addr <= r_ptr;
                            r_triggered <= 1'b1;
                            r_state     <= (r_post_cnt == '0) ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        r_post_cnt <= r_post_cnt - ADDR_W'(1);
                        if (r_post_cnt == ADDR_W'(1))
                            r_state <= S_DONE;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_ring_writer.sv
// Directed bench for capture_ring_writer; expected writes are queued as beats are
// driven and popped by a monitor as the memory writes appear.
module tb_capture_ring_writer;
    localparam int AW = 19;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, arm, abort, trigger, sample_valid;
    logic [AW-1:0] start_addr, pre_count, post_count;
    logic [DW-1:0] sample_data;
    logic          sample_ready, mem_chipselect, mem_write, busy, done, triggered, wrapped;
    logic [AW-1:0] mem_address, trig_addr;
    logic [DW-1:0] mem_writedata;
    logic [3:0]    mem_byteenable;

    always #5 clk = ~clk;

    capture_ring_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .start_addr(start_addr), .pre_count(pre_count), .post_count(post_count),
        .trigger(trigger), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(sample_ready), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .busy(busy),
        .done(done), .triggered(triggered), .wrapped(wrapped), .trig_addr(trig_addr)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           q[$];
    wr_t           mon_e;
    logic [AW-1:0] m_ptr;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            chk("wr_pending", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("wr_addr", 64'(mem_address), 64'(mon_e.a));
                chk("wr_data", 64'(mem_writedata), 64'(mon_e.d));
                chk("wr_cs", 64'(mem_chipselect), 64'd1);
                chk("wr_be", 64'(mem_byteenable), 64'hF);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic do_arm(input logic [AW-1:0] sa, input logic [AW-1:0] pr, input logic [AW-1:0] po);
        arm = 1'b1; start_addr = sa; pre_count = pr; post_count = po;
        m_ptr = sa;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic trig, input logic acc);
        sample_valid = 1'b1; sample_data = d; trigger = trig;
        if (acc) begin
            q.push_back('{a: m_ptr, d: d});
            m_ptr = m_ptr + AW'(1);
        end
        @(negedge clk);
        sample_valid = 1'b0; trigger = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_mem_cs"}, 64'(mem_chipselect), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_address), 64'd0);
        chk({tag, "_mem_data"}, 64'(mem_writedata), 64'd0);
        chk({tag, "_mem_be"}, 64'(mem_byteenable), 64'hF);
        chk({tag, "_ready"}, 64'(sample_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_triggered"}, 64'(triggered), 64'd0);
        chk({tag, "_wrapped"}, 64'(wrapped), 64'd0);
        chk({tag, "_trig_addr"}, 64'(trig_addr), 64'd0);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
        start_addr = '0; pre_count = '0; post_count = '0; sample_data = '0; m_ptr = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // basic capture: pre=4, trigger on beat 7, post=3
        do_arm(19'h100, 19'd4, 19'd3);
        chk("t1_ready", 64'(sample_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 10; i++) begin
            send(DW'(32'hA0 + i), (i == 6), 1'b1);
            if (i == 5) chk("t1_not_trig", 64'(triggered), 64'd0);
            if (i == 6) begin
                chk("t1_triggered", 64'(triggered), 64'd1);
                chk("t1_trig_addr", 64'(trig_addr), 64'h106);
            end
            chk("t1_done", 64'(done), 64'(i == 9));
        end
        idle(1);
        chk("t1_ready_after", 64'(sample_ready), 64'd0);
        chk("t1_no_write", 64'(mem_write), 64'd0);
        chk("t1_done_hold", 64'(done), 64'd1);

        // rearm from DONE; trigger held high through PRE; post=0
        do_arm(19'h200, 19'd2, 19'd0);
        chk("t2_trig_clr", 64'(triggered), 64'd0);
        chk("t2_taddr_clr", 64'(trig_addr), 64'd0);
        chk("t2_done_clr", 64'(done), 64'd0);
        send(32'h1, 1'b1, 1'b1);
        send(32'h2, 1'b1, 1'b1);
        chk("t2_pre_ignores", 64'(triggered), 64'd0);
        send(32'h3, 1'b1, 1'b1);
        chk("t2_triggered", 64'(triggered), 64'd1);
        chk("t2_trig_addr", 64'(trig_addr), 64'h202);
        chk("t2_done", 64'(done), 64'd1);
        idle(1);

        // wrap across the top of the ring
        do_arm(19'h7FFFE, 19'd0, 19'd3);
        chk("t3_wrapped_clr", 64'(wrapped), 64'd0);
        send(32'hB0, 1'b1, 1'b1);
        chk("t3_trig_addr", 64'(trig_addr), 64'h7FFFE);
        chk("t3_not_wrapped", 64'(wrapped), 64'd0);
        send(32'hB1, 1'b0, 1'b1);
        chk("t3_wrapped", 64'(wrapped), 64'd1);
        send(32'hB2, 1'b0, 1'b1);
        send(32'hB3, 1'b0, 1'b1);
        chk("t3_done", 64'(done), 64'd1);
        idle(1);

        // gappy valid in POST
        do_arm(19'h300, 19'd0, 19'd3);
        send(32'hC0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("t4_gap_no_write", 64'(mem_write), 64'd0);
            send(DW'(32'hC1 + k), 1'b0, 1'b1);
            chk("t4_done", 64'(done), 64'(k == 2));
        end
        idle(1);

        // arm while busy is ignored; abort alongside an accepted beat
        do_arm(19'h400, 19'd0, 19'd5);
        send(32'hD0, 1'b0, 1'b1);
        arm = 1'b1; start_addr = 19'h555;
        send(32'hD1, 1'b0, 1'b1);
        arm = 1'b0;
        abort = 1'b1;
        send(32'hD2, 1'b0, 1'b1);
        abort = 1'b0;
        chk("t5_ready_abort", 64'(sample_ready), 64'd0);
        chk("t5_busy_abort", 64'(busy), 64'd0);
        send(32'hD3, 1'b0, 1'b0);
        chk("t5_no_write", 64'(mem_write), 64'd0);
        do_arm(19'h500, 19'd1, 19'd1);
        send(32'hE0, 1'b1, 1'b1);
        chk("t5_pre_trig", 64'(triggered), 64'd0);
        send(32'hE1, 1'b1, 1'b1);
        chk("t5_trig_addr", 64'(trig_addr), 64'h501);
        chk("t5_busy_post", 64'(busy), 64'd1);

        // synchronous reset in POST
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk_reset_vals("t6");
        idle(2);
        chk("t6_no_write", 64'(mem_write), 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
